// File: rtl/merger_stream.sv
// Two-way streaming merge of key-sorted runs: each input is buffered in its own
// FIFO, heads are compared and the winner is loaded into a single output register.
module merger_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int KEY_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter bit DESCENDING = 1'b0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CNT_WIDTH-1:0]  o_run_count,
    output logic [CNT_WIDTH-1:0]  o_rec_count,
    output logic                  o_order_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef logic [DATA_WIDTH-1:0] rec_t;
    typedef logic [KEY_WIDTH-1:0]  key_t;
    typedef logic [PW-1:0]         ptr_t;

    // Index 0 is stream A, index 1 is stream B.
    rec_t       in_data [2];
    logic [1:0] in_valid;
    rec_t       mem     [2][FIFO_DEPTH];
    ptr_t       wr_q [2], wr_d [2], rd_q [2], rd_d [2];
    key_t       last_key_q [2], last_key_d [2];
    logic [1:0] in_run_q, in_run_d;
    logic       order_err_q, order_err_d;

    rec_t       head     [2];
    key_t       head_key [2];
    key_t       in_key   [2];
    logic [1:0] head_term, full, empty, push, pop;

    rec_t                 data_q, data_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] run_q, run_d, rec_q, rec_d;
    logic                 fire, a_first;

    assign in_data[0] = i_a_data;
    assign in_data[1] = i_b_data;
    assign in_valid   = {i_b_valid, i_a_valid};

    // FIFO status, input acceptance and per-input sort-order tracking.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        order_err_d = order_err_q;
        in_run_d    = in_run_q;
        for (int s = 0; s < 2; s++) begin
            full[s]      = (wr_q[s][AW] != rd_q[s][AW]) && (wr_q[s][AW-1:0] == rd_q[s][AW-1:0]);
            empty[s]     = (wr_q[s] == rd_q[s]);
            push[s]      = in_valid[s] && !full[s];
            head[s]      = mem[s][rd_q[s][AW-1:0]];
            head_key[s]  = head[s][KEY_WIDTH-1:0];
            head_term[s] = (head_key[s] == '0);
            in_key[s]    = in_data[s][KEY_WIDTH-1:0];
            wr_d[s]      = push[s] ? wr_q[s] + PW'(1) : wr_q[s];
            last_key_d[s] = last_key_q[s];
            if (push[s]) begin
                if (in_key[s] == '0) begin
                    in_run_d[s] = 1'b0;
                end else begin
                    if (in_run_q[s] && (DESCENDING ? (in_key[s] > last_key_q[s])
                                                   : (in_key[s] < last_key_q[s])))
                        order_err_d = 1'b1;
                    last_key_d[s] = in_key[s];
                    in_run_d[s]   = 1'b1;
                end
            end
        end
    end

    // Head selection and output register load.
    always_comb begin
        fire    = (!valid_q || i_ready) && !empty[0] && !empty[1];
        a_first = DESCENDING ? (head_key[0] >= head_key[1]) : (head_key[0] <= head_key[1]);
        pop     = 2'b00;
        data_d  = data_q;
        valid_d = valid_q;
        run_d   = run_q;
        rec_d   = rec_q;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
            if (data_q[KEY_WIDTH-1:0] != '0)
                rec_d = rec_q + CNT_WIDTH'(1);
        end
        if (fire) begin
            valid_d = 1'b1;
            unique case (head_term)
                2'b00: begin
                    data_d = a_first ? head[0] : head[1];
                    pop    = a_first ? 2'b01 : 2'b10;
                end
                2'b01: begin
                    data_d = head[1];
                    pop    = 2'b10;
                end
                2'b10: begin
                    data_d = head[0];
                    pop    = 2'b01;
                end
                default: begin
                    data_d = head[0];
                    pop    = 2'b11;
                    run_d  = run_q + CNT_WIDTH'(1);
                end
            endcase
        end
        for (int s = 0; s < 2; s++)
            rd_d[s] = pop[s] ? rd_q[s] + PW'(1) : rd_q[s];
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < 2; s++)
            if (push[s])
                mem[s][wr_q[s][AW-1:0]] <= in_data[s];
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < 2; s++) begin
                wr_q[s]       <= '0;
                rd_q[s]       <= '0;
                last_key_q[s] <= '0;
            end
            in_run_q    <= '0;
            order_err_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            run_q       <= '0;
            rec_q       <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_q[s]       <= wr_d[s];
                rd_q[s]       <= rd_d[s];
                last_key_q[s] <= last_key_d[s];
            end
            in_run_q    <= in_run_d;
            order_err_q <= order_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            run_q       <= run_d;
            rec_q       <= rec_d;
        end
    end

    assign o_a_ready   = !full[0];
    assign o_b_ready   = !full[1];
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_run_count = run_q;
    assign o_rec_count = rec_q;
    assign o_order_err = order_err_q;

endmodule

// File: tb/tb_merger_stream.sv
// Bench for merger_stream: directed scenarios plus random sorted runs, checked
// against a queue-based merge model of the two input streams.
module tb_merger_stream;

    localparam int DW = 64;
    localparam int KW = 32;
    localparam int CW = 32;

    typedef logic [DW-1:0] rec_t;
    typedef logic [KW-1:0] key_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    rec_t          i_a_data = '0, i_b_data = '0;
    logic          i_a_valid = 1'b0, i_b_valid = 1'b0, i_ready = 1'b0;
    logic          o_a_ready, o_b_ready, o_valid, o_order_err;
    rec_t          o_data;
    logic [CW-1:0] o_run_count, o_rec_count;
    logic          d_a_ready, d_b_ready, d_valid, d_order_err;
    rec_t          d_data;
    logic [CW-1:0] d_run_count, d_rec_count;

    merger_stream u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_data(i_a_data), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
        .i_b_data(i_b_data), .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_run_count(o_run_count), .o_rec_count(o_rec_count), .o_order_err(o_order_err)
    );

    merger_stream #(.DESCENDING(1'b1)) u_desc (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_data(i_a_data), .i_a_valid(i_a_valid), .o_a_ready(d_a_ready),
        .i_b_data(i_b_data), .i_b_valid(i_b_valid), .o_b_ready(d_b_ready),
        .o_data(d_data), .o_valid(d_valid), .i_ready(i_ready),
        .o_run_count(d_run_count), .o_rec_count(d_rec_count), .o_order_err(d_order_err)
    );

    always #5 i_clk = ~i_clk;

    int   checks = 0;
    int   errors = 0;
    rec_t fa[$], fb[$];
    rec_t ma[$], mb[$], exp_q[$], out_log[$], desc_log[$];
    int   exp_runs, exp_recs;
    bit   exp_err;
    key_t last_key [2];
    bit   in_run [2];
    int   e25 [7] = '{1, 2, 3, 4, 9, 10, 0};
    int   e27 [4] = '{9, 7, 3, 0};

    function automatic rec_t mk(input int unsigned tag, input int unsigned key);
        return {tag, key};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference merge: ascending order, tie to A, terminators pair up into a run end.
    function automatic void model_merge();
        while (ma.size() > 0 && mb.size() > 0) begin
            key_t ka = ma[0][KW-1:0];
            key_t kb = mb[0][KW-1:0];
            rec_t r;
            if (ka != 0 && kb != 0) r = (ka <= kb) ? ma.pop_front() : mb.pop_front();
            else if (ka == 0 && kb != 0) r = mb.pop_front();
            else if (ka != 0 && kb == 0) r = ma.pop_front();
            else begin
                r = ma.pop_front();
                void'(mb.pop_front());
                exp_runs++;
            end
            exp_q.push_back(r);
            if (r[KW-1:0] != 0) exp_recs++;
        end
    endfunction

    function automatic void model_accept(input int side, input rec_t r);
        key_t k = r[KW-1:0];
        if (k == 0) in_run[side] = 1'b0;
        else begin
            if (in_run[side] && k < last_key[side]) exp_err = 1'b1;
            last_key[side] = k;
            in_run[side] = 1'b1;
        end
        if (side == 0) ma.push_back(r); else mb.push_back(r);
        model_merge();
    endfunction

    function automatic void model_flush();
        ma.delete(); mb.delete(); exp_q.delete(); out_log.delete(); desc_log.delete();
        exp_runs = 0; exp_recs = 0; exp_err = 1'b0;
        for (int s = 0; s < 2; s++) begin
            last_key[s] = '0;
            in_run[s] = 1'b0;
        end
    endfunction

    // Transfers are decided on the coming rising edge; sample them mid-cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (i_a_valid && o_a_ready) model_accept(0, i_a_data);
            if (i_b_valid && o_b_ready) model_accept(1, i_b_data);
            if (o_valid && i_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out_extra observed=%0h expected=none", o_data);
                end
                if (exp_q.size() != 0) check("out_seq", o_data, exp_q.pop_front());
                out_log.push_back(o_data);
            end
            if (d_valid && i_ready) desc_log.push_back(d_data);
        end
    end

    task automatic reset_dut();
        @(posedge i_clk); #1;
        i_rst_n = 1'b0; i_a_valid = 1'b0; i_b_valid = 1'b0; i_ready = 1'b1;
        model_flush();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    // Streams fa/fb into the inputs; pa/pr are valid/ready probabilities in percent.
    task automatic feed(input int pa, input int pr);
        int ia = 0, ib = 0, n = 0;
        while ((ia < fa.size() || ib < fb.size()) && n < 5000) begin
            i_a_valid = (ia < fa.size()) && ($urandom_range(1, 100) <= pa);
            if (ia < fa.size()) i_a_data = fa[ia];
            i_b_valid = (ib < fb.size()) && ($urandom_range(1, 100) <= pa);
            if (ib < fb.size()) i_b_data = fb[ib];
            i_ready = ($urandom_range(1, 100) <= pr);
            @(negedge i_clk);
            if (i_a_valid && o_a_ready) ia++;
            if (i_b_valid && o_b_ready) ib++;
            @(posedge i_clk); #1;
            n++;
        end
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        check("feed_timeout", n < 5000, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        i_ready = 1'b1;
        while (n < 500 && !(exp_q.size() == 0 && !o_valid)) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("drain_timeout", n < 500, 1'b1);
    endtask

    task automatic gen_streams(input int runs);
        fa.delete(); fb.delete();
        for (int r = 0; r < runs; r++) begin
            for (int s = 0; s < 2; s++) begin
                int unsigned k = $urandom_range(1, 20);
                int len = $urandom_range(0, 5);
                for (int j = 0; j < len; j++) begin
                    if (s == 0) fa.push_back(mk($urandom, k)); else fb.push_back(mk($urandom, k));
                    k += $urandom_range(0, 30);
                end
                if (s == 0) fa.push_back(mk($urandom, 0)); else fb.push_back(mk($urandom, 0));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        model_flush();
        #1 i_rst_n = 1'b0;
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, '0);
        check("rst_runs", o_run_count, '0);
        check("rst_recs", o_rec_count, '0);
        check("rst_err", o_order_err, 1'b0);
        check("rst_a_ready", o_a_ready, 1'b1);
        check("rst_b_ready", o_b_ready, 1'b1);
        check("rst_d_a_ready", d_a_ready, 1'b1);
        check("rst_d_b_ready", d_b_ready, 1'b1);

        // First edge after release accepts; result visible one edge later.
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_ready = 1'b1;
        i_a_data = mk(1, 3); i_a_valid = 1'b1;
        i_b_data = mk(2, 5); i_b_valid = 1'b1;
        @(posedge i_clk); #1;
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        check("lat_k_valid", o_valid, 1'b0);
        @(posedge i_clk); #1;
        check("lat_k1_valid", o_valid, 1'b1);
        check("lat_k1_data", o_data, mk(1, 3));

        // Basic two-run merge.
        reset_dut();
        fa = '{mk(1, 1), mk(1, 4), mk(1, 9), mk(1, 0)};
        fb = '{mk(2, 2), mk(2, 3), mk(2, 10), mk(2, 0)};
        feed(100, 100);
        wait_drain();
        check("m25_len", out_log.size(), 7);
        for (int i = 0; i < 7; i++)
            check("m25_key", (i < out_log.size()) ? out_log[i][KW-1:0] : '1, e25[i]);
        check("m25_runs", o_run_count, 1);
        check("m25_recs", o_rec_count, 6);
        check("m25_err", o_order_err, 1'b0);

        // Equal keys go to A first.
        reset_dut();
        fa = '{mk(1, 5), mk(2, 5), mk(3, 0)};
        fb = '{mk(4, 5), mk(5, 0)};
        feed(100, 100);
        wait_drain();
        check("tie_len", out_log.size(), 4);
        check("tie_0", out_log[0], mk(1, 5));
        check("tie_1", out_log[1], mk(2, 5));
        check("tie_2", out_log[2], mk(4, 5));
        check("tie_3", out_log[3], mk(3, 0));

        // Descending instance; the ascending instance just follows its model.
        reset_dut();
        fa = '{mk(1, 9), mk(1, 3), mk(1, 0)};
        fb = '{mk(2, 7), mk(2, 0)};
        feed(100, 100);
        wait_drain();
        repeat (3) @(posedge i_clk);
        #1;
        check("desc_len", desc_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("desc_key", (i < desc_log.size()) ? desc_log[i][KW-1:0] : '1, e27[i]);
        check("desc_runs", d_run_count, 1);
        check("desc_recs", d_rec_count, 3);
        check("desc_err", d_order_err, 1'b0);
        check("asc_err_model", o_order_err, exp_err);

        // Fill A with B empty: nothing may come out.
        reset_dut();
        fa.delete(); fb.delete();
        for (int i = 1; i <= 16; i++) fa.push_back(mk(7, i));
        feed(100, 100);
        check("full_a_ready", o_a_ready, 1'b0);
        check("full_b_ready", o_b_ready, 1'b1);
        check("full_valid", o_valid, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        check("full_wait_valid", o_valid, 1'b0);
        fa.delete();
        fb = '{mk(8, 1000)};
        feed(100, 100);
        wait_drain();
        check("full_recs", o_rec_count, 16);
        check("full_a_ready_after", o_a_ready, 1'b1);

        // Back-pressure hold, then full rate.
        reset_dut();
        fa = '{mk(1, 1), mk(1, 3), mk(1, 5), mk(1, 7), mk(1, 9), mk(1, 11), mk(1, 0)};
        fb = '{mk(2, 2), mk(2, 4), mk(2, 6), mk(2, 8), mk(2, 10), mk(2, 12), mk(2, 0)};
        feed(100, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            check("hold_valid", o_valid, 1'b1);
            check("hold_data", o_data, mk(1, 1));
        end
        i_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge i_clk);
            check("rate_valid", o_valid, 1'b1);
        end
        @(negedge i_clk);
        check("rate_end_valid", o_valid, 1'b0);
        @(posedge i_clk); #1;
        check("rate_recs", o_rec_count, 12);
        check("rate_runs", o_run_count, 1);
        check("rate_left", exp_q.size(), 0);

        // Random sorted runs with random valid/ready.
        for (int round = 0; round < 2; round++) begin
            reset_dut();
            gen_streams(8);
            if (round == 0) feed(60, 70); else feed(100, 100);
            wait_drain();
            check("rnd_runs", o_run_count, 8);
            check("rnd_recs", o_rec_count, exp_recs);
            check("rnd_err", o_order_err, 1'b0);
        end

        // Sticky order error, then asynchronous reset mid-stream.
        reset_dut();
        fb.delete();
        fa = '{mk(1, 4)};
        feed(100, 100);
        check("oe_after_4", o_order_err, 1'b0);
        fa = '{mk(1, 2)};
        feed(100, 100);
        check("oe_after_2", o_order_err, 1'b1);
        fa = '{mk(1, 0)};
        feed(100, 100);
        check("oe_after_term", o_order_err, 1'b1);
        fa.delete();
        fb = '{mk(2, 1), mk(2, 6)};
        feed(100, 100);
        wait_drain();
        check("oe_recs", o_rec_count, 4);
        check("oe_sticky", o_order_err, 1'b1);
        fb = '{mk(2, 7)};
        feed(100, 0);
        @(posedge i_clk); #1;
        check("pre_rst_valid", o_valid, 1'b1);
        check("pre_rst_data", o_data, mk(2, 7));
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_data", o_data, '0);
        check("mid_rst_runs", o_run_count, '0);
        check("mid_rst_recs", o_rec_count, '0);
        check("mid_rst_err", o_order_err, 1'b0);
        check("mid_rst_a_ready", o_a_ready, 1'b1);
        check("mid_rst_b_ready", o_b_ready, 1'b1);
        model_flush();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/merger_stream.md
MERGER_STREAM -- requirements
Module: merger_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: record width in bits.
REQ-002 SHALL have parameter KEY_WIDTH, default 32: sort key = record bits [KEY_WIDTH-1:0]; KEY_WIDTH <= DATA_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: entries per input FIFO, power of two >= 2.
REQ-004 SHALL have parameter DESCENDING, default 0: 0 merges ascending, 1 merges descending.
REQ-005 SHALL have parameter CNT_WIDTH, default 32: width of the statistics counters.
REQ-006 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_a_data  in  DATA_WIDTH  input stream A record.
- i_a_valid  in  1  A record present.
- o_a_ready  out  1  A FIFO can accept.
- i_b_data  in  DATA_WIDTH  input stream B record.
- i_b_valid  in  1  B record present.
- o_b_ready  out  1  B FIFO can accept.
- o_data  out  DATA_WIDTH  merged record.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.
- o_run_count  out  CNT_WIDTH  merged runs completed.
- o_rec_count  out  CNT_WIDTH  non-terminator records emitted.
- o_order_err  out  1  sticky input sort-order violation.

Function
REQ-007 Each input stream SHALL be a sequence of sorted runs; a record with key 0 is the run terminator.
REQ-008 An input transfer SHALL occur on a rising edge where valid and ready are both 1; o_a_ready = A FIFO not full (likewise B), independent of i_a_valid.
REQ-009 Each input SHALL be buffered in its own FIFO_DEPTH-entry FIFO; pointers wrap modulo FIFO_DEPTH; full/empty SHALL use an extra pointer bit; simultaneous push and pop on a full FIFO SHALL NOT be allowed (ready is low).
REQ-010 The output stage SHALL be one register; it loads when (o_valid=0 or i_ready=1) and both FIFOs are non-empty ("fire"); an output transfer is o_valid & i_ready.
REQ-011 On fire, with heads HA, HB, the selection SHALL be:
- neither is a terminator: emit the lesser key (greater if DESCENDING=1); tie emits A; pop only the emitted FIFO.
- A is a terminator, B is not: emit HB, pop B.
- B is a terminator, A is not: emit HA, pop A.
- both are terminators: emit HA once, pop both, increment o_run_count.
REQ-012 The merge SHALL wait while either FIFO is empty, even when the other head is a terminator.
REQ-013 If fire does not occur and o_valid=1 with i_ready=0, o_data and o_valid SHALL hold unchanged.
REQ-014 o_valid SHALL fall on the edge after a transfer when no fire occurs on that edge.
REQ-015 Latency: a record pushed into an empty FIFO at edge k, with the other head present and the output free, SHALL appear with o_valid=1 after edge k+1.
REQ-016 Throughput SHALL be one record per cycle while both FIFOs are non-empty and i_ready=1.
REQ-017 o_rec_count SHALL increment on each output transfer whose key is non-zero; both counters wrap modulo 2^CNT_WIDTH.
REQ-018 Per input, the block SHALL hold the last accepted key and an in-run flag; a non-terminator key out of order (smaller than the last when ascending, larger when descending) within a run SHALL set o_order_err.
REQ-019 A terminator SHALL clear that input's in-run flag; o_order_err SHALL never clear except by reset.
REQ-020 Out-of-order data SHALL still be merged per REQ-011; the error is report-only.

Reset
REQ-021 While i_rst_n=0, the block SHALL immediately (asynchronously) reset: both FIFOs empty, o_valid=0, o_data=0, both counters 0, o_order_err=0, in-run flags clear.
REQ-022 Under reset, o_a_ready and o_b_ready SHALL be 1.
REQ-023 Reset asserted mid-run SHALL discard all buffered and in-flight records.
REQ-024 Release of i_rst_n SHALL be synchronous to i_clk, and the block SHALL accept input on the first edge after release.

Verification
REQ-025 A=[1,4,9,0], B=[2,3,10,0], i_ready=1 -> output 1,2,3,4,9,10,0; o_run_count=1; o_rec_count=6.
REQ-026 A=[5,5,0], B=[5,0] -> output A5,A5,B5,0, with the ties taking A first (distinguished by upper data bits).
REQ-027 DESCENDING=1, A=[9,3,0], B=[7,0] -> output 9,7,3,0.
REQ-028 Push 16 records into A with B empty -> o_a_ready=0 after the 16th; nothing is emitted until B has a record.
REQ-029 Hold i_ready=0 for 5 cycles mid-stream -> o_data stable, no record lost or duplicated, and full rate resumes afterwards.
REQ-030 A=[4,2,0] -> o_order_err=1 after 2 is accepted and stays 1; pulse i_rst_n low mid-stream -> all outputs 0 and o_valid=0 immediately.
